// File: rtl/router_pkg.sv
// Shared types and elaboration helpers for the router receive path.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    PAD,
    DATA
  } rx_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a counter that must hold values 0..n-1; never below 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_rx_fifo.sv
// Synchronous show-ahead FIFO with registered valid, almost-full and occupancy.
module router_rx_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic             head_valid,
  output logic             afull,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             afull_q, afull_d;
  logic             push_ok, pop_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop && valid_q;
  assign push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    afull_d = (count_d >= CNT_W'(DEPTH - 1));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      afull_q  <= afull_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked while empty instead.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head_data  = valid_q ? mem[rd_ptr_q] : '0;
  assign head_valid = valid_q;
  assign afull      = afull_q;
  assign count      = count_q;

endmodule

// File: rtl/router_rx_deframer.sv
// Serial-to-parallel receive deframer with output FIFO; define ROUTER_RX_STATS_EN
// to build the saturating packet/error counters (otherwise they read 0).
module router_rx_deframer
  import router_pkg::*;
#(
  parameter int PORTS      = 16,  // at least 4
  parameter int DATA_W     = 8,   // at least 2
  parameter int PAD_CYCLES = 4,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_W    = $clog2(PORTS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              din,
  input  logic              frame_n,
  input  logic              valid_n,
  output logic              busy_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_sop,
  output logic              out_eop,
  output logic              err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } rx_word_t;

  localparam int CNT_W  = cnt_width(max3(ADDR_W, DATA_W, PAD_CYCLES));
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              first_q, first_d;
  logic              err_q, err_d;
  logic              push, proto_err, pop, drop, fifo_afull;
  rx_word_t          push_word, head;
  logic [FCNT_W-1:0] fifo_count;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    first_d   = first_q;
    push      = 1'b0;
    push_word = '0;
    proto_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!frame_n) begin
          addr_d  = {din, addr_q[ADDR_W-1:1]};
          cnt_d   = CNT_W'(1);
          first_d = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (frame_n) begin
          proto_err = 1'b1;
          state_d   = IDLE;
        end else begin
          addr_d = {din, addr_q[ADDR_W-1:1]};
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d   = '0;
            state_d = PAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PAD: begin
        if (frame_n) begin
          proto_err = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(PAD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (!valid_n) begin
          // LSB-first: after DATA_W shifts the first bit has reached bit 0.
          data_d = {din, data_q[DATA_W-1:1]};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            push      = 1'b1;
            push_word = '{addr: addr_q, data: data_d, sop: first_q, eop: frame_n};
            first_d   = 1'b0;
            cnt_d     = '0;
            if (frame_n) state_d = IDLE;
          end else if (frame_n) begin
            proto_err = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (frame_n) begin
          // Ending on a gap is clean only at a word boundary after at least one word.
          proto_err = first_q || (cnt_q != '0);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop   = out_valid && out_ready;
  assign drop  = push && (fifo_count == FCNT_W'(FIFO_DEPTH)) && !pop;
  assign err_d = proto_err || drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  router_rx_fifo #(
    .W     ($bits(rx_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (push_word),
    .pop        (pop),
    .head_data  (head),
    .head_valid (out_valid),
    .afull      (fifo_afull),
    .count      (fifo_count)
  );

  assign busy_n   = !fifo_afull;
  assign err      = err_q;
  assign out_data = head.data;
  assign out_addr = head.addr;
  assign out_sop  = head.sop;
  assign out_eop  = head.eop;

`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push && push_word.eop && !drop && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_rx_deframer.sv
// Directed self-checking bench for router_rx_deframer at default parameters.
module tb_router_rx_deframer;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int PAD_CYCLES = 4;
  localparam int FIFO_DEPTH = 16;
`ifdef ROUTER_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              din = 1'b0;
  logic              frame_n = 1'b1;
  logic              valid_n = 1'b1;
  logic              out_ready = 1'b0;
  logic              busy_n, out_valid, out_sop, out_eop, err;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       pkt_cnt, err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int err_pulses = 0;
  int err_base;

  router_rx_deframer #(
    .PORTS      (16),
    .DATA_W     (DATA_W),
    .PAD_CYCLES (PAD_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .din       (din),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .busy_n    (busy_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .err       (err),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clock = ~clock;

  // Counts cycles in which err was high (read before this edge updates it).
  always @(posedge clock) if (err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic drive(input logic f, input logic v, input logic d);
    @(negedge clock);
    frame_n = f;
    valid_n = v;
    din     = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_hdr(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < ADDR_W; i++) drive(1'b0, 1'b1, a[i]);
    repeat (PAD_CYCLES) drive(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [DATA_W-1:0] b, input bit last);
    for (int i = 0; i < DATA_W; i++) drive(last && (i == DATA_W - 1), 1'b0, b[i]);
  endtask

  // Checks the FIFO head, then pops it over one clock edge.
  task automatic pop_check(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic s, input logic e);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_addr"},  out_addr,  a);
    check({tag, "_data"},  out_data,  d);
    check({tag, "_sop"},   out_sop,   s);
    check({tag, "_eop"},   out_eop,   e);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy_n"},    busy_n,    1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"},  out_data,  '0);
    check({tag, "_out_addr"},  out_addr,  '0);
    check({tag, "_out_sop"},   out_sop,   1'b0);
    check({tag, "_out_eop"},   out_eop,   1'b0);
    check({tag, "_err"},       err,       1'b0);
    check({tag, "_pkt_cnt"},   pkt_cnt,   16'd0);
    check({tag, "_err_cnt"},   err_cnt,   16'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    frame_n = 1'b1;
    valid_n = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    idle(2);

    // Single packet: addr 5, bytes A5 then 3C, no gaps.
    send_hdr(4'd5);
    send_byte(8'hA5, 1'b0);
    check("sp_valid_before_edge", out_valid, 1'b0);
    @(posedge clock);
    #1;
    check("sp_valid_after_edge", out_valid, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(1);
    pop_check("sp_w0", 4'd5, 8'hA5, 1'b1, 1'b0);
    pop_check("sp_w1", 4'd5, 8'h3C, 1'b0, 1'b1);
    check("sp_empty", out_valid, 1'b0);
    check("sp_no_err", err_pulses, 0);

    // Gapped payload: 3 idle cycles in the middle of 0x81.
    send_hdr(4'd9);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == 4) repeat (3) drive(1'b0, 1'b1, 1'b0);
      drive(i == DATA_W - 1, 1'b0, (i == 0) || (i == 7));
    end
    idle(1);
    pop_check("gap", 4'd9, 8'h81, 1'b1, 1'b1);
    check("gap_no_err", err_pulses, 0);

    // Abort in the second pad cycle.
    err_base = err_pulses;
    for (int i = 0; i < ADDR_W; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    check("abort_pad_err", err_pulses - err_base, 1);
    check("abort_pad_empty", out_valid, 1'b0);

    // Abort after three payload bits.
    err_base = err_pulses;
    send_hdr(4'd6);
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    check("abort_data_err", err_pulses - err_base, 1);
    check("abort_data_empty", out_valid, 1'b0);

    // Backpressure: 16 bytes fill the FIFO, the 17th is dropped.
    err_base = err_pulses;
    send_hdr(4'd2);
    for (int i = 0; i < 17; i++) begin
      send_byte(8'h40 + 8'(i), i == 16);
      @(posedge clock);
      #1;
      if (i == 13) check("bp_busy_at_14", busy_n, 1'b1);
      if (i == 14) check("bp_busy_at_15", busy_n, 1'b0);
      if (i == 15) check("bp_no_drop_at_16", err_pulses - err_base, 0);
    end
    idle(2);
    check("bp_drop_err", err_pulses - err_base, 1);
    check("bp_busy_full", busy_n, 1'b0);
    for (int i = 0; i < FIFO_DEPTH; i++)
      pop_check($sformatf("bp_w%0d", i), 4'd2, 8'h40 + 8'(i), i == 0, 1'b0);
    check("bp_drained", out_valid, 1'b0);
    check("bp_busy_drained", busy_n, 1'b1);
    check("stats_err_cnt", err_cnt, STATS ? 16'd3 : 16'd0);

    // Back-to-back single-byte packets after a fresh reset.
    do_reset();
    idle(1);
    send_hdr(4'd3);
    send_byte(8'h11, 1'b1);
    send_hdr(4'd12);
    send_byte(8'h22, 1'b1);
    idle(1);
    pop_check("b2b_p0", 4'd3, 8'h11, 1'b1, 1'b1);
    pop_check("b2b_p1", 4'd12, 8'h22, 1'b1, 1'b1);
    check("b2b_pkt_cnt", pkt_cnt, STATS ? 16'd2 : 16'd0);

    // Reset mid-payload with a word already buffered.
    send_hdr(4'd7);
    send_byte(8'hC3, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b1);
    check("mid_valid_before_reset", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    frame_n = 1'b1;
    valid_n = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    err_base = err_pulses;
    send_hdr(4'd10);
    send_byte(8'h5A, 1'b1);
    idle(1);
    pop_check("post_rst", 4'd10, 8'h5A, 1'b1, 1'b1);
    check("post_rst_empty", out_valid, 1'b0);
    check("post_rst_no_err", err_pulses - err_base, 0);
    check("post_rst_pkt_cnt", pkt_cnt, STATS ? 16'd1 : 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
